// File: rtl/avmm_copy_pkg.sv
// Shared definitions for the Avalon-MM copy/fill master.
// Contents: FSM state encoding, mode constants, default widths.
package avmm_copy_pkg;

  localparam int unsigned DEF_ADDR_W      = 14;
  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_MAX_RD_WAIT = 255;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/avmm_copy_master_if.sv
// Avalon-MM word-addressed bus bundle between a master and the fabric.
// master modport: drives address/read/write/writedata/byteenable,
//                 receives readdata/waitrequest/readdatavalid.
// slave modport : the mirror image.
interface avmm_copy_master_if
  import avmm_copy_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0]   avm_address;
  logic                avm_read;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_waitrequest;
  logic                avm_readdatavalid;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_readdata, avm_waitrequest, avm_readdatavalid
  );

endinterface

// File: rtl/avmm_copy_timeout.sv
// Loadable down-counter with an expired flag.
// Ports: clk, rst_n (async, active low), load_i/load_val_i (load has priority),
//        en_i (decrement, saturates at zero), expired_o (count is zero).
module avmm_copy_timeout #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/avmm_copy_master.sv
// Avalon-MM master that copies len words from src to dst (COPY) or writes a
// constant pattern to len words at dst (FILL). Honours waitrequest and
// readdatavalid; a read that never returns raises a sticky error.
// Ports: clk, reset_n (async, active low); control start/mode/src_addr/
//        dst_addr/len/pattern/abort; status busy/done/error/words_done;
//        avm: Avalon-MM master bundle.
module avmm_copy_master
  import avmm_copy_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned MAX_RD_WAIT = DEF_MAX_RD_WAIT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] pattern,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_done,
  avmm_copy_master_if.master avm
);

  localparam int unsigned TO_W = $clog2(MAX_RD_WAIT + 1);

  state_t            state_q;
  logic              mode_q, busy_q, done_q, error_q, abort_pend_q;
  logic              read_q, write_q;
  logic [ADDR_W-1:0] src_q, dst_q, len_q, idx_q, addr_q;
  // Holds the fill pattern, or the last word read in COPY mode.
  logic [DATA_W-1:0] wdata_q;

  logic [ADDR_W-1:0] idx_d, rd_next_d, wr_cur_d, wr_next_d;
  logic              stop_d, rd_beat_d, to_load, to_en, to_expired;

  always_comb begin
    idx_d     = idx_q + ADDR_W'(1);
    rd_next_d = src_q + idx_d;
    wr_cur_d  = dst_q + idx_q;
    wr_next_d = dst_q + idx_d;
    stop_d    = abort | abort_pend_q;
    // Read data is taken either in RD_WAIT or, for a zero-latency slave,
    // in the very cycle RD_REQ is accepted.
    rd_beat_d = avm.avm_readdatavalid &&
                ((state_q == ST_RD_WAIT) ||
                 ((state_q == ST_RD_REQ) && !avm.avm_waitrequest));
    to_load   = (state_q == ST_RD_REQ);
    to_en     = (state_q == ST_RD_WAIT);
  end

  // Loaded with MAX_RD_WAIT-1 so RD_WAIT lasts at most MAX_RD_WAIT cycles.
  avmm_copy_timeout #(.W(TO_W)) u_timeout (
    .clk       (clk),
    .rst_n     (reset_n),
    .load_i    (to_load),
    .load_val_i(TO_W'(MAX_RD_WAIT - 1)),
    .en_i      (to_en),
    .expired_o (to_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_COPY;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      abort_pend_q <= 1'b0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      // Abort is remembered and acted on at the next transaction boundary.
      if ((state_q != ST_IDLE) && abort) abort_pend_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          // busy is still high for one cycle after FINISH; starts are
          // ignored until it has dropped.
          busy_q <= 1'b0;
          if (start && !busy_q) begin
            mode_q       <= mode;
            src_q        <= src_addr;
            dst_q        <= dst_addr;
            len_q        <= len;
            wdata_q      <= pattern;
            idx_q        <= '0;
            error_q      <= 1'b0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b1;
            if (len == '0) begin
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end else if (mode == MODE_COPY) begin
              read_q  <= 1'b1;
              addr_q  <= src_addr;
              state_q <= ST_RD_REQ;
            end else begin
              write_q <= 1'b1;
              addr_q  <= dst_addr;
              state_q <= ST_WR_REQ;
            end
          end
        end

        // RD_REQ and RD_WAIT share one arm so the zero-latency capture and the
        // normal capture use the same exit path; later assignments win.
        ST_RD_REQ, ST_RD_WAIT: begin
          if ((state_q == ST_RD_REQ) && !avm.avm_waitrequest) begin
            read_q  <= 1'b0;
            state_q <= ST_RD_WAIT;
          end
          if (rd_beat_d) begin
            wdata_q <= avm.avm_readdata;
            if (stop_d) begin
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end else begin
              write_q <= 1'b1;
              addr_q  <= wr_cur_d;
              state_q <= ST_WR_REQ;
            end
          end else if ((state_q == ST_RD_WAIT) && to_expired) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end
        end

        ST_WR_REQ: begin
          if (!avm.avm_waitrequest) begin
            idx_q <= idx_d;
            if ((idx_d == len_q) || stop_d) begin
              write_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end else if (mode_q == MODE_COPY) begin
              write_q <= 1'b0;
              read_q  <= 1'b1;
              addr_q  <= rd_next_d;
              state_q <= ST_RD_REQ;
            end else begin
              addr_q <= wr_next_d;
            end
          end
        end

        ST_FINISH: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = error_q;
  // The write index counts accepted writes, so it doubles as words_done.
  assign words_done         = idx_q;
  assign avm.avm_address    = addr_q;
  assign avm.avm_read       = read_q;
  assign avm.avm_write      = write_q;
  assign avm.avm_writedata  = wdata_q;
  assign avm.avm_byteenable = '1;

endmodule

// File: tb/tb_avmm_copy_master.sv
// Directed bench for avmm_copy_master with a behavioural Avalon-MM memory
// slave (configurable waitrequest, read latency, or no read response).
module tb_avmm_copy_master;
  import avmm_copy_pkg::*;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] src_addr = '0, dst_addr = '0, len = '0;
  logic [DW-1:0] pattern = '0;
  logic          busy, done, error;
  logic [AW-1:0] words_done;

  avmm_copy_master_if #(.ADDR_W(AW), .DATA_W(DW)) avm ();

  avmm_copy_master #(.ADDR_W(AW), .DATA_W(DW), .MAX_RD_WAIT(255)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .pattern(pattern),
    .abort(abort), .busy(busy), .done(done), .error(error),
    .words_done(words_done), .avm(avm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave knobs, written only by the stimulus block.
  bit slv_rand_wait = 1'b0;
  bit slv_hold      = 1'b0;
  bit slv_no_rdv    = 1'b0;
  int slv_lat_min   = 0;
  int slv_lat_max   = 0;

  // Memory and bus logs, written only by the bus monitor.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit            mem_valid [0:(1<<AW)-1];
  int            cyc = 0;
  int            rd_acc = 0;
  int            overlap = 0;
  int            unstable = 0;
  int            wr_cyc [$];
  logic [AW-1:0] wr_addr [$];

  // Unwritten locations read as 0x11*(addr+1): 0->0x11, 1->0x22, 2->0x33.
  function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
    if (mem_valid[a]) return mem[a];
    return DW'(32'h11 * (32'(a) + 1));
  endfunction

  // Slave response: decided on the falling edge for the cycle that follows.
  bit            pend_valid = 1'b0;
  int            pend_cnt = 0;
  logic [DW-1:0] pend_data = '0;
  always @(negedge clk) begin
    logic          w, rdv;
    logic [DW-1:0] rd;
    int            l;
    rdv = 1'b0;
    rd  = '0;
    if (pend_valid) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        rdv = 1'b1;
        rd = pend_data;
        pend_valid = 1'b0;
      end
    end
    w = slv_hold ? 1'b1 : (slv_rand_wait ? 1'($urandom_range(1, 0)) : 1'b0);
    if (avm.avm_read && !w && !slv_no_rdv) begin
      l = int'($urandom_range(slv_lat_max, slv_lat_min));
      if (l == 0) begin
        rdv = 1'b1;
        rd = rd_word(avm.avm_address);
      end else begin
        pend_valid = 1'b1;
        pend_cnt = l;
        pend_data = rd_word(avm.avm_address);
      end
    end
    avm.avm_waitrequest   = w;
    avm.avm_readdatavalid = rdv;
    avm.avm_readdata      = rd;
  end

  // Bus monitor: memory writes, stall stability, read/write overlap.
  bit                   prev_stall = 1'b0;
  logic [AW+DW+1:0]     prev_sig = '0;
  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (avm.avm_read && avm.avm_write) overlap++;
      if (prev_stall &&
          ({avm.avm_read, avm.avm_write, avm.avm_address, avm.avm_writedata} !== prev_sig))
        unstable++;
      prev_stall = (avm.avm_read || avm.avm_write) && avm.avm_waitrequest;
      prev_sig = {avm.avm_read, avm.avm_write, avm.avm_address, avm.avm_writedata};
      if (avm.avm_read && !avm.avm_waitrequest) rd_acc++;
      if (avm.avm_write && !avm.avm_waitrequest) begin
        mem[avm.avm_address] = avm.avm_writedata;
        mem_valid[avm.avm_address] = 1'b1;
        wr_cyc.push_back(cyc);
        wr_addr.push_back(avm.avm_address);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues a one-cycle start, then waits (bounded) for done; n is the number
  // of cycles after the start cycle at which done was seen.
  task automatic run(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                     input logic [AW-1:0] l, input logic [DW-1:0] p,
                     input int limit, output int n);
    mode = m; src_addr = s; dst_addr = d; len = l; pattern = p; start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while ((done !== 1'b1) && (n < limit)) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n, wb, ob, ub, rb;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_words", words_done, 0);
    chk("rst_rw", {avm.avm_read, avm.avm_write}, 0);
    chk("rst_addr", avm.avm_address, 0);
    chk("rst_wdata", avm.avm_writedata, 0);
    chk("rst_be", avm.avm_byteenable, 4'hF);
    reset_n = 1'b1;
    step();

    // FILL 4 words at 0x10, zero-wait slave
    wb = wr_addr.size();
    run(MODE_FILL, 14'h0, 14'h10, 14'd4, 32'hDEADBEEF, 50, n);
    chk("fill_done_cyc", n, 5);
    chk("fill_words", words_done, 4);
    chk("fill_nwr", wr_addr.size() - wb, 4);
    if (wr_addr.size() - wb == 4) begin
      chk("fill_b2b", wr_cyc[wb+3] - wr_cyc[wb], 3);
      for (int i = 0; i < 4; i++) chk("fill_addr", wr_addr[wb+i], 14'h10 + 14'(i));
    end
    for (int i = 0; i < 4; i++) chk("fill_mem", mem[14'h10 + 14'(i)], 32'hDEADBEEF);
    step();
    chk("fill_done_pulse", done, 0);
    chk("fill_busy_tail", busy, 1);
    step();
    chk("fill_busy_off", busy, 0);

    // COPY 3 words 0x0 -> 0x100, 1-cycle read latency
    slv_lat_min = 1; slv_lat_max = 1;
    ob = overlap;
    run(MODE_COPY, 14'h0, 14'h100, 14'd3, 32'h0, 100, n);
    chk("copy_done_cyc", n, 10);
    chk("copy_words", words_done, 3);
    chk("copy_m0", mem[14'h100], 32'h11);
    chk("copy_m1", mem[14'h101], 32'h22);
    chk("copy_m2", mem[14'h102], 32'h33);
    chk("copy_overlap", overlap - ob, 0);
    step(); step();

    // COPY zero latency, destination wraps 0x3FFF -> 0x0000
    slv_lat_min = 0; slv_lat_max = 0;
    run(MODE_COPY, 14'h5, 14'h3FFF, 14'd2, 32'h0, 100, n);
    chk("zl_done_cyc", n, 5);
    chk("zl_m3fff", mem[14'h3FFF], 32'h66);
    chk("zl_m0000", mem[14'h0000], 32'h77);
    step(); step();

    // COPY with random waitrequest and 0..5 read latency
    slv_rand_wait = 1'b1; slv_lat_min = 0; slv_lat_max = 5;
    ob = overlap; ub = unstable;
    run(MODE_COPY, 14'h20, 14'h300, 14'd6, 32'h0, 2000, n);
    chk("rnd_done", done, 1);
    chk("rnd_words", words_done, 6);
    for (int i = 0; i < 6; i++)
      chk("rnd_mem", mem[14'h300 + 14'(i)], 32'h11 * (33 + i));
    chk("rnd_stable", unstable - ub, 0);
    chk("rnd_overlap", overlap - ob, 0);
    slv_rand_wait = 1'b0; slv_lat_min = 0; slv_lat_max = 0;
    step(); step();

    // len = 0: no bus activity, done next cycle, busy for 2 cycles
    wb = wr_addr.size(); rb = rd_acc;
    run(MODE_COPY, 14'h0, 14'h200, 14'd0, 32'h0, 10, n);
    chk("len0_done_cyc", n, 1);
    chk("len0_busy1", busy, 1);
    step();
    chk("len0_busy2", busy, 1);
    chk("len0_done_off", done, 0);
    step();
    chk("len0_busy3", busy, 0);
    chk("len0_nobus", (wr_addr.size() - wb) + (rd_acc - rb), 0);

    // Read that never returns: timeout after 255 wait cycles
    slv_no_rdv = 1'b1;
    run(MODE_COPY, 14'h40, 14'h400, 14'd2, 32'h0, 400, n);
    chk("to_done_cyc", n, 257);
    chk("to_error", error, 1);
    chk("to_words", words_done, 0);
    step(); step();
    chk("to_sticky", error, 1);
    slv_no_rdv = 1'b0;
    run(MODE_FILL, 14'h0, 14'h500, 14'd1, 32'hA5A5A5A5, 20, n);
    chk("to_clear_cyc", n, 2);
    chk("to_cleared", error, 0);
    chk("to_fill_mem", mem[14'h500], 32'hA5A5A5A5);
    step(); step();

    // Abort during the 2nd write of an 8-word FILL
    wb = wr_addr.size();
    mode = MODE_FILL; dst_addr = 14'h600; len = 14'd8; pattern = 32'h12345678;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_done", done, 1);
    chk("abort_words", words_done, 2);
    chk("abort_nwr", wr_addr.size() - wb, 2);
    step(); step();

    // Reset in the middle of a stalled COPY read
    slv_hold = 1'b1;
    mode = MODE_COPY; src_addr = 14'h0; dst_addr = 14'h700; len = 14'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("mid_read", avm.avm_read, 1);
    reset_n = 1'b0;
    #1;
    chk("mrst_rw", {avm.avm_read, avm.avm_write}, 0);
    chk("mrst_status", {busy, done, error}, 0);
    chk("mrst_addr", avm.avm_address, 0);
    chk("mrst_words", words_done, 0);
    chk("mrst_be", avm.avm_byteenable, 4'hF);
    step();
    reset_n = 1'b1;
    slv_hold = 1'b0;
    step(); step();
    chk("mrst_no_resume", {busy, avm.avm_read, avm.avm_write}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
